// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
package mem_stage_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } mem_state_e;

  localparam int unsigned ALIGN_BITS = 3;
  localparam int unsigned REG_ADDR_W = 5;

  // Doubleword accesses must have the low address bits clear.
  function automatic logic is_aligned(input logic [ALIGN_BITS-1:0] low_bits);
    return (low_bits == '0);
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/grant/response bus between the memory stage and data memory.
interface memory_stage_if #(
  parameter int unsigned N = 64
);
  logic         dm_req;
  logic         dm_we;
  logic [N-1:0] dm_addr;
  logic [N-1:0] dm_wdata;
  logic         dm_gnt;
  logic         dm_rvalid;
  logic [N-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/pipe_reg_en.sv
// Generic pipeline register: asynchronous active-low clear, load on enable.
module pipe_reg_en #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: EX/MEM register, data-memory handshake FSM, branch resolve, MEM/WB register.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_E,
  input  logic                  memRead_E,
  input  logic                  memWrite_E,
  input  logic                  branch_E,
  input  logic                  regWrite_E,
  input  logic                  memtoReg_E,
  input  logic [REG_ADDR_W-1:0] rd_E,
  input  logic [N-1:0]          PCBranch_E,
  input  logic [N-1:0]          aluResult_E,
  input  logic [N-1:0]          writeData_E,
  input  logic                  zero_E,
  memory_stage_if.master        dm,
  output logic                  stall_M,
  output logic                  PCSrc_M,
  output logic [N-1:0]          PCBranch_M,
  output logic                  valid_W,
  output logic                  regWrite_W,
  output logic                  memtoReg_W,
  output logic [REG_ADDR_W-1:0] rd_W,
  output logic [N-1:0]          aluResult_W,
  output logic [N-1:0]          readData_W,
  output logic                  fault_W
);

  localparam int unsigned EXM_W = 7 + REG_ADDR_W + 3 * N;
  localparam int unsigned MWB_W = 2 + REG_ADDR_W + N;

  logic                  valid_M, memRead_M, memWrite_M, branch_M;
  logic                  regWrite_M, memtoReg_M, zero_M;
  logic [REG_ADDR_W-1:0] rd_M;
  logic [N-1:0]          aluResult_M, writeData_M;

  logic       aligned, mem_op, misaligned;
  logic       req, done, load_done;
  mem_state_e state, state_next;

  pipe_reg_en #(.W(EXM_W)) ex_mem (
    .clk   (clk),
    .rst_n (reset),
    .en    (!stall_M),
    .d     ({valid_E, memRead_E, memWrite_E, branch_E, regWrite_E, memtoReg_E, zero_E,
             rd_E, PCBranch_E, aluResult_E, writeData_E}),
    .q     ({valid_M, memRead_M, memWrite_M, branch_M, regWrite_M, memtoReg_M, zero_M,
             rd_M, PCBranch_M, aluResult_M, writeData_M})
  );

  assign aligned    = is_aligned(aluResult_M[ALIGN_BITS-1:0]);
  assign mem_op     = valid_M & (memRead_M | memWrite_M);
  assign misaligned = mem_op & !aligned;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stray grants in WAIT_DATA and stray rvalids in IDLE fall through untouched.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    done       = 1'b0;
    load_done  = 1'b0;
    unique case (state)
      IDLE: begin
        req = mem_op & aligned;
        if (req && dm.dm_gnt) begin
          if (memWrite_M) begin
            done = 1'b1;
          end else begin
            state_next = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (dm.dm_rvalid) begin
          done       = 1'b1;
          load_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign stall_M      = mem_op & aligned & !done;
  assign dm.dm_req    = req;
  assign dm.dm_we     = memWrite_M;
  assign dm.dm_addr   = aluResult_M;
  assign dm.dm_wdata  = writeData_M;
  assign PCSrc_M      = valid_M & branch_M & zero_M;

  pipe_reg_en #(.W(MWB_W)) mem_wb (
    .clk   (clk),
    .rst_n (reset),
    .en    (!stall_M),
    .d     ({regWrite_M & !misaligned, memtoReg_M, rd_M, aluResult_M}),
    .q     ({regWrite_W, memtoReg_W, rd_W, aluResult_W})
  );

  // Loaded every edge so a stalled cycle drops a bubble and fault lasts one cycle.
  pipe_reg_en #(.W(2)) wb_flags (
    .clk   (clk),
    .rst_n (reset),
    .en    (1'b1),
    .d     ({valid_M & !stall_M, misaligned}),
    .q     ({valid_W, fault_W})
  );

  pipe_reg_en #(.W(N)) wb_rdata (
    .clk   (clk),
    .rst_n (reset),
    .en    (load_done),
    .d     (dm.dm_rdata),
    .q     (readData_W)
  );

endmodule
